// File: rtl/nco_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_ctrl_pkg
// Description : Shared definitions for the NCO sweep controller: default
//               widths, controller state encoding and the saturating
//               frequency-step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_ctrl_pkg;

    localparam int DEF_INC_W   = 8;
    localparam int DEF_DWELL_W = 16;
    localparam int DEF_PRE_W   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } sweep_state_t;

    // Next phase increment: cur +/- step computed one bit wider than the
    // increment so a carry or borrow is visible, then clamped to stop. The
    // result never passes stop and never wraps.
    function automatic logic [DEF_INC_W-1:0] sat_step(
        input logic [DEF_INC_W-1:0] cur,
        input logic [DEF_INC_W-1:0] stop,
        input logic [DEF_INC_W-1:0] step,
        input logic                 up
    );
        logic [DEF_INC_W:0] wide;
        sat_step = stop;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            if (wide <= {1'b0, stop}) begin
                sat_step = wide[DEF_INC_W-1:0];
            end
        end else begin
            wide = {1'b0, cur} - {1'b0, step};
            if (!wide[DEF_INC_W] && (wide >= {1'b0, stop})) begin
                sat_step = wide[DEF_INC_W-1:0];
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl_if
// Description : Control/config and NCO-facing signal bundle of the sweep
//               controller.
//               master : control logic (drives start/abort/config, observes
//                        status and NCO drive)
//               slave  : nco_sweep_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface nco_sweep_ctrl_if
    import nco_ctrl_pkg::*;
#(
    parameter int INC_W   = DEF_INC_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int PRE_W   = DEF_PRE_W
);
    // Control and configuration
    logic               start;
    logic               abort;
    logic               continuous;
    logic [INC_W-1:0]   start_inc;
    logic [INC_W-1:0]   stop_inc;
    logic [INC_W-1:0]   step_inc;
    logic [DWELL_W-1:0] dwell;
    logic [PRE_W-1:0]   prescale;

    // NCO drive and status
    logic [INC_W-1:0]   phase_increment;
    logic               clk_en;
    logic               busy;
    logic               hop;
    logic               done;

    modport master (
        output start, abort, continuous, start_inc, stop_inc, step_inc,
               dwell, prescale,
        input  phase_increment, clk_en, busy, hop, done
    );

    modport slave (
        input  start, abort, continuous, start_inc, stop_inc, step_inc,
               dwell, prescale,
        output phase_increment, clk_en, busy, hop, done
    );
endinterface
`default_nettype wire

// File: rtl/nco_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : nco_prescaler
// Description : Divide-by-(prescale+1) tick generator used to pace the NCO.
//               tick is a look-ahead: it is high when the count being
//               entered on the next edge equals prescale, so the parent can
//               register it and present clk_en in exactly that cycle.
// Ports       : clock, reset (async, active-high), clear (restart the count
//               at 0 on the next edge), prescale (divide value), tick (out)
// Revision    : 1.0 - initial release
// ============================================================================
module nco_prescaler
    import nco_ctrl_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic [PRE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRE_W-1:0] r_cnt;
    logic [PRE_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt + PRE_W'(1);
        if (clear || (r_cnt >= prescale)) begin
            w_cnt_next = '0;
        end
    end

    assign tick = (w_cnt_next == prescale);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Frequency sweep sequencer for the 8-bit phase-accumulator
//               NCO. Steps phase_increment from start_inc to stop_inc,
//               holding each value for dwell NCO ticks, with the tick rate
//               set by a prescaler driving clk_en.
// Ports       : clock, reset (async, active-high)
//               bus (slave) : start/abort/continuous and latched config in;
//                             phase_increment, clk_en, busy, hop, done out
//                             (all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    // INC_W must equal DEF_INC_W: the saturating step helper is sized by it.
    parameter int INC_W   = DEF_INC_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int PRE_W   = DEF_PRE_W
) (
    input  wire logic        clock,
    input  wire logic        reset,
    nco_sweep_ctrl_if.slave  bus
);

    // Latched sweep configuration
    logic [INC_W-1:0]   r_start;
    logic [INC_W-1:0]   r_stop;
    logic [INC_W-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [PRE_W-1:0]   r_prescale;
    logic               r_cont;
    logic               r_up;

    sweep_state_t       r_state;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [INC_W-1:0]   r_inc;
    logic               r_clk_en;
    logic               r_busy;
    logic               r_hop;
    logic               r_done;

    logic               w_start_ok;
    logic               w_last_tick;
    logic               w_at_stop;
    logic               w_finish;
    logic               w_load;
    logic               w_run_next;
    logic               w_tick;
    logic               w_pre_clear;
    logic [PRE_W-1:0]   w_pre_val;
    logic [INC_W-1:0]   w_step_in;
    logic [DWELL_W-1:0] w_dwell_in;
    logic [INC_W-1:0]   w_next_inc;

    assign w_start_ok  = (r_state == IDLE) && bus.start && !bus.abort;
    // clk_en is registered, so the dwell-th tick is the one the NCO sees
    // this cycle; the new increment lands on the following cycle.
    assign w_last_tick = (r_state == DWELL) && r_clk_en &&
                         (r_dwell_cnt == (r_dwell - DWELL_W'(1)));
    assign w_at_stop   = (r_inc == r_stop);
    assign w_finish    = w_last_tick && w_at_stop && !r_cont;
    assign w_load      = !bus.abort && (w_start_ok || (w_last_tick && !w_finish));
    assign w_run_next  = w_start_ok ||
                         ((r_state == DWELL) && !bus.abort && !w_finish);

    assign w_step_in   = (bus.step_inc == '0) ? INC_W'(1) : bus.step_inc;
    assign w_dwell_in  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign w_next_inc  = w_at_stop ? r_start : sat_step(r_inc, r_stop, r_step, r_up);

    // In IDLE the prescaler is held cleared and sees the live prescale input,
    // so the first clk_en after a start is already paced correctly.
    assign w_pre_clear = w_load || (r_state == IDLE);
    assign w_pre_val   = (r_state == IDLE) ? bus.prescale : r_prescale;

    nco_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_pre_clear),
        .prescale (w_pre_val),
        .tick     (w_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= '0;
            r_prescale  <= '0;
            r_cont      <= 1'b0;
            r_up        <= 1'b0;
            r_dwell_cnt <= '0;
            r_inc       <= '0;
            r_clk_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_hop       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_hop    <= 1'b0;
            r_done   <= 1'b0;
            r_clk_en <= w_run_next && w_tick;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_start     <= bus.start_inc;
                        r_stop      <= bus.stop_inc;
                        r_step      <= w_step_in;
                        r_dwell     <= w_dwell_in;
                        r_prescale  <= bus.prescale;
                        r_cont      <= bus.continuous;
                        r_up        <= (bus.stop_inc >= bus.start_inc);
                        r_inc       <= bus.start_inc;
                        r_dwell_cnt <= '0;
                        r_hop       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= DWELL;
                    end
                end
                DWELL: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_finish) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_last_tick) begin
                        r_inc       <= w_next_inc;
                        r_hop       <= 1'b1;
                        r_dwell_cnt <= '0;
                    end else if (r_clk_en) begin
                        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.phase_increment = r_inc;
    assign bus.clk_en          = r_clk_en;
    assign bus.busy            = r_busy;
    assign bus.hop             = r_hop;
    assign bus.done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_sweep_ctrl
// Description : Self-checking bench for nco_sweep_ctrl. Each sweep pushes
//               its expected increment sequence into a queue; every hop
//               pops and compares, and the cycles/ticks spent on each
//               frequency are checked against dwell*(prescale+1) and dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    nco_sweep_ctrl_if bus ();

    nco_sweep_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input bit chk_inc);
        check({tag, "_clk_en"}, int'(bus.clk_en), 0);
        check({tag, "_busy"},   int'(bus.busy),   0);
        check({tag, "_hop"},    int'(bus.hop),    0);
        check({tag, "_done"},   int'(bus.done),   0);
        if (chk_inc) check({tag, "_inc"}, int'(bus.phase_increment), 0);
    endtask

    // Starts a sweep at the current negedge and follows it to done, or for
    // continuous sweeps to the stop_after-th hop, which is then aborted.
    // poke: at cycle 3 raise start again and scramble all config inputs.
    task automatic run_sweep(input int s, input int e, input int st,
                             input int dw, input int pre, input bit cont,
                             input int stop_after, input bit poke);
        int  stp, dwl, cur, n_exp, hops, gap, ticks, cyc, first_en, done_seen;
        bit  up, fin;
        stp = (st == 0) ? 1 : st;
        dwl = (dw == 0) ? 1 : dw;
        up  = (e >= s);
        exp_q.delete();
        cur = s;
        exp_q.push_back(s);
        while ((cont && exp_q.size() < stop_after) || (!cont && cur != e)) begin
            if (cur == e)  cur = s;
            else if (up)   cur = (cur + stp > e) ? e : cur + stp;
            else           cur = (cur - stp < e) ? e : cur - stp;
            exp_q.push_back(cur);
        end
        n_exp = exp_q.size();

        bus.start_inc  = 8'(s);
        bus.stop_inc   = 8'(e);
        bus.step_inc   = 8'(st);
        bus.dwell      = 16'(dw);
        bus.prescale   = 8'(pre);
        bus.continuous = cont;
        bus.start      = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;

        cyc = 1; hops = 0; gap = 0; ticks = 0; first_en = -1; fin = 0;
        while (!fin && cyc < 3000) begin
            if (poke && cyc == 3) begin
                bus.start      = 1'b1;
                bus.start_inc  = 8'd77;
                bus.stop_inc   = 8'd3;
                bus.step_inc   = 8'd50;
                bus.dwell      = 16'd9;
                bus.prescale   = 8'd5;
                bus.continuous = ~cont;
            end else begin
                bus.start = 1'b0;
            end

            if (bus.hop) begin
                if (hops == 0) begin
                    check("first_hop_cycle", cyc, 1);
                    check("busy_after_start", int'(bus.busy), 1);
                end else begin
                    check("dwell_cycles", gap, dwl * (pre + 1));
                    check("dwell_ticks", ticks, dwl);
                end
                if (exp_q.size() == 0) check("hop_count", hops + 1, n_exp);
                else check("phase_inc", int'(bus.phase_increment), exp_q.pop_front());
                hops++;
                gap   = 0;
                ticks = 0;
                if (cont && hops == stop_after) begin
                    bus.abort = 1'b1;
                    @(negedge clock);
                    bus.abort = 1'b0;
                    check("abort_busy", int'(bus.busy), 0);
                    check("abort_clk_en", int'(bus.clk_en), 0);
                    done_seen = int'(bus.done);
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clock);
                        done_seen += int'(bus.done);
                    end
                    check("abort_no_done", done_seen, 0);
                    fin = 1;
                end
            end

            if (!fin) begin
                if (bus.done) begin
                    check("done_when_continuous", int'(cont), 0);
                    check("final_cycles", gap, dwl * (pre + 1));
                    check("final_ticks", ticks, dwl);
                    check("done_busy", int'(bus.busy), 0);
                    check("done_clk_en", int'(bus.clk_en), 0);
                    check("hops_total", hops, n_exp);
                    fin = 1;
                end else begin
                    if (bus.clk_en) begin
                        ticks++;
                        if (first_en < 0) begin
                            first_en = cyc;
                            check("first_clk_en", cyc, 1 + pre);
                        end
                    end
                    gap++;
                    @(negedge clock);
                    cyc++;
                end
            end
        end
        bus.start = 1'b0;
        check("sweep_finished", int'(fin), 1);
        @(negedge clock);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.continuous = 1'b0;
        bus.start_inc  = '0;
        bus.stop_inc   = '0;
        bus.step_inc   = '0;
        bus.dwell      = '0;
        bus.prescale   = '0;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset", 1'b1);
        reset = 1'b0;
        @(negedge clock);

        // Basic up-sweep, with a start request and config changes mid-sweep.
        run_sweep(10, 40, 10, 2, 0, 1'b0, 0, 1'b1);
        // Saturation near the top of the range, prescaled.
        run_sweep(250, 255, 4, 1, 3, 1'b0, 0, 1'b0);
        // Down-sweep, continuous, aborted after five frequencies.
        run_sweep(40, 5, 20, 1, 0, 1'b1, 5, 1'b0);
        // Zero step and zero dwell behave as one.
        run_sweep(3, 5, 0, 0, 0, 1'b0, 0, 1'b0);
        // Single frequency, prescaled, multi-tick dwell.
        run_sweep(99, 99, 7, 3, 2, 1'b0, 0, 1'b0);
        // Single frequency continuous: repeats with hop each dwell.
        run_sweep(60, 60, 1, 2, 1, 1'b1, 4, 1'b0);

        // start together with abort in IDLE is refused.
        bus.start_inc = 8'd12;
        bus.stop_inc  = 8'd20;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", int'(bus.busy), 0);
        check("start_abort_hop", int'(bus.hop), 0);

        // Asynchronous reset in the middle of a sweep.
        bus.start_inc  = 8'd10;
        bus.stop_inc   = 8'd200;
        bus.step_inc   = 8'd1;
        bus.dwell      = 16'd3;
        bus.prescale   = 8'd1;
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        check("pre_reset_busy", int'(bus.busy), 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_reset", 1'b1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_sweep(100, 130, 15, 1, 2, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the 8-bit phase-accumulator NCO. Drives the NCO's `phase_increment` and `clk_en` inputs to step its output frequency from a start increment to a stop increment. Each frequency is held for a programmable number of NCO ticks, and the NCO tick rate is set by a programmable prescaler. Sits between the control/config logic and the NCO instance; one controller per NCO.

## Interface
- `INC_W`, 8, width of phase increment (matches NCO)
- `DWELL_W`, 16, width of dwell tick counter
- `PRE_W`, 8, width of clk_en prescaler

- `clock` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: request sweep; sampled only in IDLE
- `abort` in 1: stop sweep immediately
- `continuous` in 1: restart from start increment at end of sweep (latched at start)
- `start_inc` in INC_W: first phase increment (latched at start)
- `stop_inc` in INC_W: final phase increment (latched at start)
- `step_inc` in INC_W: unsigned step magnitude; 0 treated as 1 (latched)
- `dwell` in DWELL_W: NCO ticks per frequency; 0 treated as 1 (latched)
- `prescale` in PRE_W: clk_en asserted once every prescale+1 cycles (latched)
- `phase_increment` out INC_W: to NCO
- `clk_en` out 1: to NCO
- `busy` out 1: sweep active
- `hop` out 1: one-cycle pulse when `phase_increment` is (re)loaded
- `done` out 1: one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, DWELL. All outputs are registered.
- IDLE:
  - `clk_en`=0 and `busy`=0. `phase_increment` holds its last value.
  - When `start`=1 and `abort`=0: latch config, load `phase_increment`=start_inc, pulse `hop`, clear the prescale and dwell counters, go to DWELL.
- DWELL:
  - The prescale counter counts 0..prescale. `clk_en`=1 on each cycle the counter equals prescale (every cycle if prescale=0). Each asserted `clk_en` is one tick.
  - After the dwell-th tick, the next cycle takes one of two paths.
  - If current==stop_inc:
    - continuous=1: reload start_inc, pulse `hop`, stay in DWELL.
    - continuous=0: go to IDLE, pulse `done`, `clk_en`=0.
  - Otherwise: update the increment, pulse `hop`, clear the counters.
- Direction is up if stop_inc ≥ start_inc, else down, fixed for the sweep.
- Next increment is current ± step computed at INC_W+1 bits, saturated to stop_inc. It never passes stop_inc and never wraps modulo 2^INC_W.
- start_inc==stop_inc: single frequency. Terminates after one dwell, or repeats with `hop` each dwell when continuous=1.
- `abort` in any state: next cycle IDLE, `clk_en`=0, `busy`=0, no `done`. `abort` wins over a simultaneous `start`.
- `start` while busy is ignored. Config input changes during a sweep have no effect.
- `reset` asserted (any time, including mid-sweep):
  - State goes to IDLE; all counters are cleared.
  - `phase_increment`=0, `clk_en`=0, `busy`=0, `hop`=0, `done`=0.

## Timing
- `start` sampled in cycle 0 → cycle 1: `busy`=1, `phase_increment`=start_inc, `hop`=1.
- First `clk_en` in cycle 1+prescale; thereafter every prescale+1 cycles.
- Dwell-th tick in cycle t → cycle t+1: new `phase_increment` (with `hop`) or `done`.
- After a hop, the next `clk_en` is in cycle t+1+prescale.
- Each frequency therefore lasts exactly dwell×(prescale+1) cycles.
- The NCO never sees a tick with a stale increment.
- `done` and `busy` falling occur in the same cycle. A new `start` is accepted in that cycle (IDLE).
- `abort` in cycle a → cycle a+1: `busy`=0, `clk_en`=0.

## Structure
- Shared package `nco_ctrl_pkg` holds:
  - the state enum (IDLE, DWELL);
  - default widths INC_W/DWELL_W/PRE_W;
  - the helper function for the saturating step (INC_W+1-bit add/sub, clamp to stop).
- Sub-module `nco_prescaler`:
  - ports: clock, reset, clear, prescale → tick;
  - reused as the `clk_en` generator; the parent clears it on every load.
- The dwell counter and increment register live in the top.

## Test plan
- start=10, stop=40, step=10, dwell=2, prescale=0, start@0:
  - `phase_increment` is 10 in cycles 1–2, 20 in 3–4, 30 in 5–6, 40 in 7–8; `clk_en` high in cycles 1–8.
  - `hop` in cycles 1, 3, 5, 7; `done` and `busy`=0 in cycle 9.
- start=250, stop=255, step=4, dwell=1, prescale=3:
  - increments 250, 254, 255 (saturated, no wrap); `clk_en` once per 4 cycles; exactly 3 ticks total.
- start=40, stop=5, step=20, dwell=1, continuous=1:
  - sequence 40, 20, 5, 40, 20…; `done` never pulses; `abort` → `clk_en`=0 and `busy`=0 next cycle, no `done`.
- step=0, dwell=0, start=3, stop=5, prescale=0:
  - treated as step=1, dwell=1 → increments 3, 4, 5 on consecutive cycles, then `done`.
- `start` during busy is ignored; `start`+`abort` in IDLE stays IDLE.
- `reset` asserted mid-sweep, asynchronously between clock edges:
  - all outputs go to 0 immediately;
  - after release, a new `start` runs a full sweep from start_inc.
